pspi_ss_sched: RTL and testbench

- Slave-select scheduler for the PSPI master.
- Arbitrates four requesters, one per slave, round-robin, and drives the slave-select demux inputs (ss[1:0], s).
- Sequences setup, start, completion, hold and guard timing around each parity-SPI transfer performed by the shift engine.
- Sits between the requester interfaces and the demux/shift-engine pair.

---
 rtl/pspi_ss_sched.sv | 126 ++++++++++++
 tb/tb_pspi_ss_sched.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pspi_ss_sched.sv
// Slave-select scheduler for the PSPI master: round-robin grant of four
// requesters plus setup/start/hold/guard sequencing of the demux select.
module pspi_ss_sched #(
   parameter int unsigned SETUP_CYC   = 2,
   parameter int unsigned HOLD_CYC    = 2,
   parameter int unsigned GUARD_CYC   = 4,
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter int unsigned CNT_W       = 11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] ss,
   output logic       s,
   output logic       start,
   output logic       busy,
   output logic       timeout_err
);

   typedef enum logic [2:0] {
      IDLE, SETUP, START, ACTIVE, HOLD, GUARD
   } state_t;

   state_t           state;
   logic [1:0]       last;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       pick;
   logic [1:0]       idx;
   logic             found;

   // Search upward from the slot after the last one served, wrapping.
   always_comb begin
      pick  = last;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= 4; k++) begin
         idx = last + 2'(k);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         last        <= 2'd3;
         cnt         <= '0;
         gnt         <= '0;
         ss          <= 2'b00;
         s           <= 1'b1;
         start       <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         start       <= 1'b0;
         timeout_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (found) begin
                  state <= SETUP;
                  gnt   <= 4'b0001 << pick;
                  ss    <= pick;
                  s     <= 1'b0;
                  busy  <= 1'b1;
                  last  <= pick;
                  cnt   <= '0;
               end
            end
            SETUP: begin
               if (cnt == CNT_W'(SETUP_CYC - 1)) begin
                  state <= START;
                  start <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            START: begin
               state <= ACTIVE;
               cnt   <= '0;
            end
            ACTIVE: begin
               // done takes precedence over a timeout in the same cycle
               if (done) begin
                  state <= HOLD;
                  cnt   <= '0;
               end else if (TIMEOUT_CYC != 0 &&
                            cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  state       <= HOLD;
                  timeout_err <= 1'b1;
                  cnt         <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (cnt == CNT_W'(HOLD_CYC - 1)) begin
                  state <= GUARD;
                  s     <= 1'b1;
                  gnt   <= '0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GUARD: begin
               if (cnt == CNT_W'(GUARD_CYC - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pspi_ss_sched.sv
// Bench for pspi_ss_sched: vector table, directed corner sequences and a
// random run checked against a transaction-timeline reference model.
module tb_pspi_ss_sched;

   localparam int SETUP_CYC   = 2;
   localparam int HOLD_CYC    = 2;
   localparam int GUARD_CYC   = 4;
   localparam int TIMEOUT_CYC = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic       done = 1'b0;
   logic [3:0] gnt;
   logic [1:0] ss;
   logic       s;
   logic       start;
   logic       busy;
   logic       timeout_err;
   logic [9:0] dvec;

   pspi_ss_sched #(
      .SETUP_CYC  (SETUP_CYC),
      .HOLD_CYC   (HOLD_CYC),
      .GUARD_CYC  (GUARD_CYC),
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .CNT_W      (11)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .done       (done),
      .gnt        (gnt),
      .ss         (ss),
      .s          (s),
      .start      (start),
      .busy       (busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   assign dvec = {gnt, ss, s, start, busy, timeout_err};

   int n_cmp = 0;
   int n_bad = 0;
   int n_start = 0;
   int n_err = 0;

   // Reference model: one transaction at a time, described by the cycle
   // its select fell (m_T) and the cycle it ended (m_D, -1 while open).
   int cyc = 0;
   bit m_valid = 0;
   bit m_busy = 0;
   bit m_err = 0;
   int m_last = 3;
   int m_ss = 0;
   int m_slave = 0;
   int m_T = 0;
   int m_D = -1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      int sc;
      int i;
      if (rst) begin
         m_valid = 1;
         m_busy  = 0;
         m_last  = 3;
         m_ss    = 0;
      end else if (!m_busy) begin
         for (int k = 1; k <= 4; k++) begin
            i = (m_last + k) % 4;
            if (!m_busy && req[2'(i)]) begin
               m_busy  = 1;
               m_slave = i;
               m_last  = i;
               m_ss    = i;
               m_T     = cyc + 1;
               m_D     = -1;
               m_err   = 0;
            end
         end
      end else begin
         sc = m_T + SETUP_CYC;
         if (m_D < 0 && cyc > sc) begin
            if (done) begin
               m_D = cyc;
            end else if (TIMEOUT_CYC != 0 && cyc == sc + TIMEOUT_CYC) begin
               m_D   = cyc;
               m_err = 1;
            end
         end
         if (m_D >= 0 && cyc + 1 == m_D + 1 + HOLD_CYC + GUARD_CYC)
            m_busy = 0;
      end
      cyc++;
   endtask

   function automatic logic [9:0] model_out();
      logic [3:0] g;
      logic sv, st, bz, te;
      int endc;
      g  = '0;
      sv = 1'b1;
      st = 1'b0;
      bz = 1'b0;
      te = 1'b0;
      if (m_busy) begin
         bz   = 1'b1;
         endc = (m_D < 0) ? 32'h3fff_ffff : m_D + 1 + HOLD_CYC;
         if (cyc < endc) begin
            sv = 1'b0;
            g  = 4'(1 << m_slave);
         end
         st = (cyc == m_T + SETUP_CYC);
         te = m_err && (cyc == m_D + 1);
      end
      return {g, 2'(m_ss), sv, st, bz, te};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      if (start === 1'b1) n_start++;
      if (timeout_err === 1'b1) n_err++;
      if (m_valid) chk("model", 32'(dvec), 32'(model_out()));
   endtask

   // sel 0 waits on start, sel 1 on busy; bounded to 64 cycles.
   task automatic wait_sig(input int sel, input logic val, input string nm);
      int n;
      n = 0;
      while (((sel == 0) ? start : busy) !== val && n < 64) begin
         tick();
         n++;
      end
      chk(nm, 32'((sel == 0) ? start : busy), 32'(val));
   endtask

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       done;
      logic [9:0] exp;
   } vec_t;

   vec_t tbl[14];
   logic [3:0] rr_exp[8];
   int n0;

   function automatic vec_t mk(input logic r, input logic [3:0] q,
                               input logic d, input logic [9:0] e);
      vec_t v;
      v.rst  = r;
      v.req  = q;
      v.done = d;
      v.exp  = e;
      return v;
   endfunction

   initial begin
      // {gnt, ss, s, start, busy, timeout_err}
      tbl[0]  = mk(1, 4'b0000, 0, {4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl[1]  = mk(1, 4'b0000, 0, {4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl[2]  = mk(1, 4'b0000, 0, {4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl[3]  = mk(0, 4'b0100, 0, {4'b0100, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0});
      tbl[4]  = mk(0, 4'b0100, 0, {4'b0100, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0});
      tbl[5]  = mk(0, 4'b0000, 0, {4'b0100, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0});
      tbl[6]  = mk(0, 4'b0000, 0, {4'b0100, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0});
      tbl[7]  = mk(0, 4'b0000, 1, {4'b0100, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0});
      tbl[8]  = mk(0, 4'b0000, 0, {4'b0100, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0});
      tbl[9]  = mk(0, 4'b0000, 0, {4'b0000, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0});
      tbl[10] = mk(0, 4'b0000, 0, {4'b0000, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0});
      tbl[11] = mk(0, 4'b0000, 0, {4'b0000, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0});
      tbl[12] = mk(0, 4'b0000, 0, {4'b0000, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0});
      tbl[13] = mk(0, 4'b0000, 0, {4'b0000, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0});
      rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                 4'b0001, 4'b0010, 4'b1000, 4'b0010};

      for (int i = 0; i < 14; i++) begin
         rst  = tbl[i].rst;
         req  = tbl[i].req;
         done = tbl[i].done;
         tick();
         chk($sformatf("vec%0d", i), 32'(dvec), 32'(tbl[i].exp));
      end

      // single transfer timing, done five cycles after start
      n0  = n_start;
      req = 4'b0001;
      wait_sig(0, 1'b1, "a_start");
      req = 4'b0000;
      repeat (5) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      chk("a_s_hold", 32'(s), 0);
      tick();
      chk("a_s_rise", 32'(s), 1);
      chk("a_gnt_off", 32'(gnt), 0);
      repeat (3) tick();
      chk("a_busy_hi", 32'(busy), 1);
      tick();
      chk("a_busy_lo", 32'(busy), 0);
      chk("a_nstart", 32'(n_start - n0), 1);

      // round-robin from reset, then a sparse request pattern
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         wait_sig(0, 1'b1, "rr_start");
         chk($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(rr_exp[i]));
         tick();
         done = 1'b1;
         if (i == 5) req = 4'b1010;
         tick();
         done = 1'b0;
      end
      req = 4'b0000;
      wait_sig(1, 1'b0, "rr_idle");

      // timeout on slave 2
      n0  = n_err;
      req = 4'b0100;
      wait_sig(0, 1'b1, "c_start");
      req = 4'b0000;
      repeat (8) tick();
      chk("c_err_early", 32'(timeout_err), 0);
      tick();
      chk("c_err", 32'(timeout_err), 1);
      chk("c_s_low", 32'(s), 0);
      tick();
      chk("c_err_off", 32'(timeout_err), 0);
      tick();
      chk("c_s_high", 32'(s), 1);
      wait_sig(1, 1'b0, "c_idle");
      chk("c_err_once", 32'(n_err - n0), 1);

      // done on the timeout cycle wins
      req = 4'b0001;
      wait_sig(0, 1'b1, "d_start");
      req = 4'b0000;
      repeat (8) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("d_no_err", 32'(timeout_err), 0);
      chk("d_hold", 32'(s), 0);
      wait_sig(1, 1'b0, "d_idle");

      // done during SETUP and START is ignored
      req = 4'b0010;
      wait_sig(1, 1'b1, "e_grant");
      req  = 4'b0000;
      done = 1'b1;
      tick();
      tick();
      chk("e_start", 32'(start), 1);
      tick();
      done = 1'b0;
      repeat (3) tick();
      chk("e_wait_s", 32'(s), 0);
      chk("e_wait_gnt", 32'(gnt), 32'(4'b0010));
      done = 1'b1;
      tick();
      done = 1'b0;
      wait_sig(1, 1'b0, "e_idle");

      // requester drops mid-ACTIVE
      req = 4'b0100;
      wait_sig(0, 1'b1, "f_start");
      repeat (2) tick();
      req = 4'b0000;
      repeat (2) tick();
      chk("f_still_gnt", 32'(gnt), 32'(4'b0100));
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("f_no_err", 32'(timeout_err), 0);
      wait_sig(1, 1'b0, "f_idle");

      // reset mid-ACTIVE, pending slave 3 served next
      req = 4'b0001;
      wait_sig(0, 1'b1, "g_start");
      tick();
      req = 4'b1000;
      rst = 1'b1;
      tick();
      chk("g_rst_s", 32'(s), 1);
      chk("g_rst_gnt", 32'(gnt), 0);
      chk("g_rst_busy", 32'(busy), 0);
      rst = 1'b0;
      tick();
      chk("g_gnt3", 32'(gnt), 32'(4'b1000));
      chk("g_ss3", 32'(ss), 3);
      req = 4'b0000;
      wait_sig(1, 1'b0, "g_idle");

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) req = 4'($urandom);
         done = ($urandom_range(0, 5) == 0);
         rst  = ($urandom_range(0, 399) == 0);
         tick();
      end
      rst  = 1'b0;
      done = 1'b0;
      req  = 4'b0000;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
